// File: rtl/accum_stencil_warp_arbiter_pkg.sv
// Shared configuration for the accumulate-warp stencil arbiter slice.
// Holds the global widths used by the warp loopers and the block-granular
// arbitration state type reused by sibling arbiters.
package accum_stencil_warp_arbiter_pkg;

   // Global configuration widths
   localparam int unsigned N_ICFG         = 4;
   localparam int unsigned GLOBAL_ADDR_BW = 32;
   localparam int unsigned WORK_BW        = 8;
   localparam int unsigned VDIM           = 3;

   // Block-granular arbiter state: free to arbitrate, or owned by one source
   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // Index width for n sources; never zero so a single source still has a tag
   function automatic int unsigned src_bw(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/accum_stencil_warp_arbiter_rr_pick.sv
// Combinational round-robin first-one finder.
// Ports:
//   req     - per-source request vector
//   ptr     - index to start scanning from (wraps modulo N_SRC)
//   gnt_idx - first requesting index at or after ptr
//   any     - at least one request is present
module accum_stencil_warp_arbiter_rr_pick
   import accum_stencil_warp_arbiter_pkg::*;
#(
   parameter  int unsigned N_SRC  = 2,
   localparam int unsigned SRC_BW = src_bw(N_SRC)
) (
   input  logic [N_SRC-1:0]  req,
   input  logic [SRC_BW-1:0] ptr,
   output logic [SRC_BW-1:0] gnt_idx,
   output logic              any
);

   // Scan N_SRC positions starting at ptr, keep the first hit
   always_comb begin
      int unsigned k;
      k       = 0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         k = (32'(ptr) + i) % N_SRC;
         if (!any && req[SRC_BW'(k)]) begin
            any     = 1'b1;
            gnt_idx = SRC_BW'(k);
         end
      end
   end

endmodule

// File: rtl/accum_stencil_warp_arbiter.sv
// Round-robin scheduler sharing one accumulate-warp stencil expansion stage
// between N_SRC warp-looper streams. A source owns the stage for a whole
// block (until its islast beat is accepted); the output is one registered
// forward stage carrying the payload plus the source tag for return routing.
// Ports:
//   i_clk, i_rst          - clock, asynchronous active-low reset
//   src_rdy / src_ack     - per-source beat valid / beat accepted (one-hot)
//   i_id .. i_stencil     - per-source beat payload
//   dst_rdy / dst_ack     - output beat valid / accepted by stencil stage
//   o_id .. o_stencil     - registered output payload
//   o_src                 - source index of the current output beat
//   o_busy                - a grant is held
module accum_stencil_warp_arbiter
   import accum_stencil_warp_arbiter_pkg::*;
#(
   parameter  int unsigned N_SRC   = 2,
   parameter  int unsigned N_CFG   = N_ICFG,
   parameter  int unsigned ABW     = GLOBAL_ADDR_BW,
   localparam int unsigned WBW     = WORK_BW,
   localparam int unsigned NCFG_BW = $clog2(N_CFG + 1),
   localparam int unsigned SRC_BW  = src_bw(N_SRC)
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst,
   input  logic [N_SRC-1:0]                     src_rdy,
   output logic [N_SRC-1:0]                     src_ack,
   input  logic [N_SRC-1:0][NCFG_BW-1:0]        i_id,
   input  logic [N_SRC-1:0][ABW-1:0]            i_linear,
   input  logic [N_SRC-1:0][VDIM-1:0][WBW-1:0]  i_bofs,
   input  logic [N_SRC-1:0]                     i_retire,
   input  logic [N_SRC-1:0]                     i_islast,
   input  logic [N_SRC-1:0]                     i_stencil,
   output logic                                 dst_rdy,
   input  logic                                 dst_ack,
   output logic [NCFG_BW-1:0]                   o_id,
   output logic [ABW-1:0]                       o_linear,
   output logic [VDIM-1:0][WBW-1:0]             o_bofs,
   output logic                                 o_retire,
   output logic                                 o_islast,
   output logic                                 o_stencil,
   output logic [SRC_BW-1:0]                    o_src,
   output logic                                 o_busy
);

   arb_state_e        state_q, state_d;
   logic [SRC_BW-1:0] grant_q, grant_d;
   logic [SRC_BW-1:0] rr_ptr_q, rr_ptr_d;
   logic [SRC_BW-1:0] pick_idx_c;
   logic              pick_any_c;
   logic              out_free_c;
   logic              accept_c;
   logic              release_c;

   // Round-robin candidate, only consulted while IDLE
   accum_stencil_warp_arbiter_rr_pick #(
      .N_SRC (N_SRC)
   ) u_rr_pick (
      .req     (src_rdy),
      .ptr     (rr_ptr_q),
      .gnt_idx (pick_idx_c),
      .any     (pick_any_c)
   );

   // Only the granted source's rdy reaches the ack path
   assign out_free_c = !dst_rdy || dst_ack;
   assign accept_c   = (state_q == LOCKED) && src_rdy[grant_q] && out_free_c;
   assign release_c  = accept_c && i_islast[grant_q];

   // One-hot ack to the owning source
   always_comb begin
      src_ack = '0;
      if (accept_c) begin
         src_ack[grant_q] = 1'b1;
      end
   end

   // Next-state: grant on IDLE, release after the islast beat is taken
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      unique case (state_q)
         IDLE: begin
            if (pick_any_c) begin
               grant_d = pick_idx_c;
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (release_c) begin
               state_d  = IDLE;
               rr_ptr_d = (grant_q == SRC_BW'(N_SRC - 1)) ? '0 : grant_q + SRC_BW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Arbitration state register
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         o_busy   <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         o_busy   <= (state_d == LOCKED);
      end
   end

   // Forward output stage: reload on accept, empty on ack without reload
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         dst_rdy   <= 1'b0;
         o_id      <= '0;
         o_linear  <= '0;
         o_bofs    <= '0;
         o_retire  <= 1'b0;
         o_islast  <= 1'b0;
         o_stencil <= 1'b0;
         o_src     <= '0;
      end else if (accept_c) begin
         dst_rdy   <= 1'b1;
         o_id      <= i_id[grant_q];
         o_linear  <= i_linear[grant_q];
         o_bofs    <= i_bofs[grant_q];
         o_retire  <= i_retire[grant_q];
         o_islast  <= i_islast[grant_q];
         o_stencil <= i_stencil[grant_q];
         o_src     <= grant_q;
      end else if (dst_ack) begin
         dst_rdy   <= 1'b0;
      end
   end

endmodule

// File: doc/accum_stencil_warp_arbiter.md
Name: accum_stencil_warp_arbiter

Overview:
- Round-robin scheduler sharing one accumulate-warp stencil expansion stage between N_SRC warp-looper streams.
- Grant is held per block: once a source wins, it owns the stage until its beat flagged islast has been accepted.
- Output is one registered (forward) stage, so the stencil stage sees clean, registered rdy/data plus a source tag for return routing.

Parameters:
- N_SRC, 2, number of requesting warp loopers (2..8)
- N_CFG, TauCfg::N_ICFG, number of configs; id width NCFG_BW = $clog2(N_CFG+1)
- ABW, TauCfg::GLOBAL_ADDR_BW, linear address width
- WBW, TauCfg::WORK_BW (localparam), block-offset width
- VDIM, TauCfg::VDIM (localparam), block-offset dimensions
- SRC_BW, $clog2(N_SRC) (derived), source tag width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-low reset
- src_rdy  in  [N_SRC]  per-source beat valid
- src_ack  out  [N_SRC]  per-source beat accepted; at most one bit high per cycle
- i_id  in  NCFG_BW x [N_SRC]  config id
- i_linear  in  ABW x [N_SRC]  linear address
- i_bofs  in  WBW x [N_SRC][VDIM]  block offsets
- i_retire  in  [N_SRC]  retire flag
- i_islast  in  [N_SRC]  last beat of block; releases grant
- i_stencil  in  [N_SRC]  stencil enable, static per source while busy
- dst_rdy  out  1  output beat valid
- dst_ack  in  1  stencil stage accepted output beat
- o_id, o_linear, o_bofs, o_retire, o_islast, o_stencil  out  as inputs  registered payload
- o_src  out  SRC_BW  source index of the current output beat
- o_busy  out  1  a grant is held

Behaviour:
- Reset (i_rst low, async): state IDLE, rr_ptr=0, grant=0, dst_rdy=0, every payload output 0, o_src=0, o_busy=0.
- FSM has two states.
  - IDLE: if any src_rdy is high, pick the first requester scanning from rr_ptr upward with wrap modulo N_SRC. Set grant to it and go to LOCKED the next cycle. No ack is issued in the IDLE cycle, so arbitration costs 1 cycle per block.
  - LOCKED: only src[grant] can be acked. Other requests are ignored; their rdy stays pending.
- Output register empty condition: out_free = !dst_rdy || dst_ack.
- Acceptance: src_ack[grant] = LOCKED && src_rdy[grant] && out_free. No combinational path from any src_rdy[k], k != grant.
- On an accepted beat:
  - Payload and o_src=grant load the output register.
  - dst_rdy=1 next cycle, so latency is 1 cycle.
- If dst_ack fires with no accepted beat in the same cycle, dst_rdy is 0 next cycle.
- Simultaneous dst_ack and src_ack: the register reloads and dst_rdy stays 1, giving full throughput of 1 beat/cycle.
- Grant release:
  - Trigger: an accepted beat with i_islast[grant]=1.
  - Next cycle: state IDLE and rr_ptr = grant+1 (wraps to 0 at N_SRC).
  - The output register may still hold that last beat. Arbitration proceeds regardless, so the next source's beat can follow back-to-back after the 1-cycle IDLE.
- o_busy = (state==LOCKED).
- Output payload holds stable while dst_rdy && !dst_ack, i.e. standard rdy/ack stall.
- src_rdy dropping while LOCKED (protocol violation by source): grant is held and no ack is issued. There is no timeout.
- N_SRC=1 degenerates to a pipeline register plus the 1-cycle IDLE bubble per block.
- Asserting reset mid-block discards the register contents and the grant. Sources must be reset together.

Decomposition:
- Shared package TauCfg: N_ICFG, GLOBAL_ADDR_BW, WORK_BW, VDIM.
- Add a state typedef enum {IDLE, LOCKED} to TauCfg for reuse by other block-granular arbiters.
- Sub-module: rr_pick (combinational round-robin first-one finder: inputs req[N_SRC] and ptr; outputs gnt_idx and any).
- The output register reuses the codebase Forward handshake primitive.

Test Plan:
- Single source, block of 3 beats: src0 rdy from cycle 1.
  - ack at cycles 2,3,4; dst_rdy at 3,4,5 with o_src=0.
  - o_islast=1 only on the 3rd beat; o_busy drops at cycle 5.
- Two sources both requesting, blocks of 2 beats each, rr_ptr=0, dst_ack tied high.
  - Order: src0,src0,(bubble),src1,src1,(bubble),src0.
  - src_ack is never high for both sources in one cycle.
- Backpressure: dst_ack held low 4 cycles mid-block.
  - o_linear stays stable throughout; src_ack=0 while dst_rdy && !dst_ack.
  - On release, 1 beat/cycle resumes.
- Wrap, N_SRC=4: grant src3 first, then requesters src1 and src3.
  - After src3 islast, rr_ptr=0 and src1 wins, then src3.
- Async reset asserted mid-block with dst_rdy=1, sampled at a non-edge time.
  - All outputs go to 0 immediately; after release, arbitration restarts from src0.
- Payload integrity: random i_linear/i_bofs/i_id/i_stencil across 3 sources, 1000 beats, random dst_ack.
  - Scoreboard matches per-source order and o_src.
  - No interleaving of sources within a block.
